hazard_unit: RTL
================

# hazard_unit

Pipeline occupancy tracker and stall/bubble controller for the five-stage MIPS datapath. It records the destination register of every instruction leaving decode and advances that record through EX, MEM and WB. From the record it produces the registered `ex_wsel`, `mem_wsel` and `wb_wsel` values that the forwarding logic compares against source registers. It also detects load-use hazards, which forwarding cannot resolve, and memory-busy conditions, and drives PC stall, ID/EX bubble and global freeze.

## Interface
Parameters:
- `REG_W`, default 5: register index width; matches `regbits_t`.

Ports:
- `CLK`  in  1  pipeline clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decode holds a real instruction this cycle.
- `issue_wsel`  in  REG_W  destination register of the decoding instruction.
- `issue_regwen`  in  1  decoding instruction writes the register file.
- `issue_is_load`  in  1  decoding instruction is `lw`/`ll`.
- `dec_rs`, `dec_rt`  in  REG_W  source registers of the decoding instruction.
- `dec_uses_rs`, `dec_uses_rt`  in  1  the decoding instruction reads each source.
- `flush`  in  1  branch/jump resolved taken; squash the decoding instruction.
- `mem_busy`  in  1  the data memory access in MEM has not completed.
- `ex_wsel`, `mem_wsel`, `wb_wsel`  out  REG_W  destination register per stage; 0 when the stage holds no register write.
- `pc_stall`  out  1  hold the PC and the IF/ID latch.
- `bubble`  out  1  load a NOP into the ID/EX latch.
- `freeze`  out  1  hold every pipeline latch.
- `stall_cycles`, `freeze_cycles`  out  `HAZ_STAT_W`  present only under `HAZARD_STATS_EN`.

## Operation
- Three slot registers: EX, MEM, WB. Each slot holds {valid, wsel, regwen, is_load}.
- Stage outputs: `X_wsel = (slot.valid && slot.regwen) ? slot.wsel : 0`.
- Load-use hazard: `load_use = issue_valid && EX.valid && EX.is_load && EX.regwen && EX.wsel != 0 && ((dec_uses_rs && dec_rs == EX.wsel) || (dec_uses_rt && dec_rt == EX.wsel))`.
- Control FSM states: RUN, LU_STALL, FREEZE. State is registered and observable for coverage only. Each clock edge selects exactly one case, in this priority order:
  1. `mem_busy`: next state FREEZE. All slots hold; `freeze=1`, `pc_stall=1`, `bubble=0`.
  2. `flush`: next state RUN. EX<=bubble, MEM<=EX, WB<=MEM. `pc_stall=0`, `bubble=1`. Flush overrides a coincident load_use.
  3. `load_use`: next state LU_STALL. EX<=bubble, MEM<=EX, WB<=MEM. `pc_stall=1`, `bubble=1`.
  4. Otherwise: next state RUN. EX<=issue fields when `issue_valid`, else bubble; MEM<=EX; WB<=MEM.
- A bubble slot is all-zero.
- `pc_stall`, `bubble` and `freeze` are combinational from the slots, inputs and priority only; they must not depend on the FSM state.
- A destination of register 0 never produces a hazard and always reads out as 0.

## Timing
- Reset (asynchronous, `nRST` low): all slots invalid, FSM in RUN, every output 0. Reset mid-stall clears all slots and counters immediately.
- Latency: an instruction issued at edge N appears on `ex_wsel` after edge N, on `mem_wsel` after N+1, and on `wb_wsel` after N+2. It clears after N+3 when no freeze occurs.
- A load-use stall lasts exactly one cycle. The stalled consumer re-presents on the next cycle and finds the load in MEM, so no hazard remains.
- `mem_busy` held for K cycles freezes for exactly K cycles. The slot contents and `X_wsel` outputs stay constant throughout.
- `flush` and `mem_busy` together: freeze wins. The flush must be re-presented by the datapath after the freeze ends.

## Configuration
- `HAZARD_STATS_EN` defined: adds two saturating counters.
  - `stall_cycles` increments on every cycle with load_use active, not flushed and not frozen.
  - `freeze_cycles` increments on every `mem_busy` cycle.
  - Both hold at all-ones and reset to 0.
- Not defined: the counters and their ports are absent, and behaviour is otherwise identical.

## Structure
- `cpu_types_pkg` gains:
  - `haz_slot_t`, a packed struct {valid, wsel: `regbits_t`, regwen, is_load}.
  - `haz_state_t`, an enum {RUN, LU_STALL, FREEZE}.
  - `HAZ_STAT_W = 16`.
- One sub-module, `sat_counter` (parameterised width, `inc` input), instantiated twice under the macro.
- Ports are grouped in `hazard_unit_if` with modports `hu` and `tb`.

## Test plan
- Issue `add $3` with `issue_regwen=1` for one cycle, then idle. Required: `ex_wsel=3`, then `mem_wsel=3`, then `wb_wsel=3`, then all 0 on successive cycles.
- Issue `lw $8`; next cycle decode `add` with `dec_rs=8`. Required: `pc_stall=1` and `bubble=1` for one cycle. The next cycle `ex_wsel=0`, `mem_wsel=8`, and the stall drops.
- Issue `lw $0`, then consumer with `dec_rt=0`. Required: no stall, and `ex_wsel=0`.
- `lw $8` in EX, consumer of $8 in decode, `flush=1` in the same cycle. Required: `pc_stall=0`, `bubble=1`, slot EX invalid.
- `mem_busy=1` for 3 cycles with `add $5` in MEM. Required: `freeze=1` for 3 cycles, `mem_wsel=5` throughout, and `wb_wsel=5` on the cycle after release. With the macro defined, `freeze_cycles=3`.
- Pull `nRST` low during a freeze. Required: all outputs 0 asynchronously and the FSM in RUN after release.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit: pipeline slot record, control FSM states, stats width.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
package hazard_unit_pkg;

    localparam int REG_BITS   = 5;
    localparam int HAZ_STAT_W = 16;

    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    typedef logic [REG_BITS-1:0] regbits_t;

    typedef struct packed {
        logic     valid;
        regbits_t wsel;
        logic     regwen;
        logic     is_load;
    } haz_slot_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } haz_state_t;

    localparam haz_slot_t BUBBLE_SLOT = '0;

    function automatic logic readsReg(input logic uses, input regbits_t src, input regbits_t dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of decode-side inputs and hazard outputs for hazard_unit.
// Counter signals exist only when HAZARD_STATS_EN is defined.
interface hazard_unit_if #(parameter int REG_W = 5);
    import hazard_unit_pkg::*;

    logic             issue_valid;
    logic [REG_W-1:0] issue_wsel;
    logic             issue_regwen;
    logic             issue_is_load;
    logic [REG_W-1:0] dec_rs;
    logic [REG_W-1:0] dec_rt;
    logic             dec_uses_rs;
    logic             dec_uses_rt;
    logic             flush;
    logic             mem_busy;

    logic [REG_W-1:0] ex_wsel;
    logic [REG_W-1:0] mem_wsel;
    logic [REG_W-1:0] wb_wsel;
    logic             pc_stall;
    logic             bubble;
    logic             freeze;
    haz_state_t       state;
`ifdef HAZARD_STATS_EN
    logic [HAZ_STAT_W-1:0] stall_cycles;
    logic [HAZ_STAT_W-1:0] freeze_cycles;
`endif

    modport hu (
        input  issue_valid, issue_wsel, issue_regwen, issue_is_load,
        input  dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, flush, mem_busy,
`ifdef HAZARD_STATS_EN
        output stall_cycles, freeze_cycles,
`endif
        output ex_wsel, mem_wsel, wb_wsel, pc_stall, bubble, freeze, state
    );

    modport tb (
        output issue_valid, issue_wsel, issue_regwen, issue_is_load,
        output dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, flush, mem_busy,
`ifdef HAZARD_STATS_EN
        input  stall_cycles, freeze_cycles,
`endif
        input  ex_wsel, mem_wsel, wb_wsel, pc_stall, bubble, freeze, state
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter used by the hazard unit statistics.
// Only compiled when HAZARD_STATS_EN is defined.
`ifdef HAZARD_STATS_EN
module sat_counter #(parameter int W = 16) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/hazard_unit.sv
// Pipeline occupancy tracker and load-use / memory-busy stall controller.
// Define HAZARD_STATS_EN to add saturating stall and freeze cycle counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_W = REG_BITS
) (
    input  logic     CLK,
    input  logic     nRST,
    hazard_unit_if.hu bus
);

    haz_slot_t  slot_q [3];
    haz_slot_t  slot_d [3];
    haz_state_t state_q;
    haz_state_t state_d;

    haz_slot_t  issueSlot;
    logic       loadUse;
    logic       pcStall;
    logic       bubbleOut;
    logic       freezeOut;

    always_comb begin
        issueSlot = BUBBLE_SLOT;
        if (bus.issue_valid) begin
            issueSlot.valid   = 1'b1;
            issueSlot.wsel    = regbits_t'(bus.issue_wsel);
            issueSlot.regwen  = bus.issue_regwen;
            issueSlot.is_load = bus.issue_is_load;
        end
    end

    // Register 0 is never a real destination, so it can never cause a hazard.
    assign loadUse = bus.issue_valid && slot_q[SLOT_EX].valid && slot_q[SLOT_EX].is_load
                   && slot_q[SLOT_EX].regwen && (slot_q[SLOT_EX].wsel != '0)
                   && (readsReg(bus.dec_uses_rs, regbits_t'(bus.dec_rs), slot_q[SLOT_EX].wsel)
                    || readsReg(bus.dec_uses_rt, regbits_t'(bus.dec_rt), slot_q[SLOT_EX].wsel));

    always_comb begin
        slot_d[SLOT_EX]  = issueSlot;
        slot_d[SLOT_MEM] = slot_q[SLOT_EX];
        slot_d[SLOT_WB]  = slot_q[SLOT_MEM];
        state_d          = RUN;
        pcStall          = 1'b0;
        bubbleOut        = 1'b0;
        freezeOut        = 1'b0;
        if (bus.mem_busy) begin
            slot_d    = slot_q;
            state_d   = FREEZE;
            pcStall   = 1'b1;
            freezeOut = 1'b1;
        end else if (bus.flush) begin
            slot_d[SLOT_EX] = BUBBLE_SLOT;
            bubbleOut       = 1'b1;
        end else if (loadUse) begin
            slot_d[SLOT_EX] = BUBBLE_SLOT;
            state_d         = LU_STALL;
            pcStall         = 1'b1;
            bubbleOut       = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 3; i++) begin
                slot_q[i] <= BUBBLE_SLOT;
            end
            state_q <= RUN;
        end else begin
            slot_q  <= slot_d;
            state_q <= state_d;
        end
    end

    assign bus.ex_wsel  = (slot_q[SLOT_EX].valid && slot_q[SLOT_EX].regwen)
                        ? REG_W'(slot_q[SLOT_EX].wsel) : '0;
    assign bus.mem_wsel = (slot_q[SLOT_MEM].valid && slot_q[SLOT_MEM].regwen)
                        ? REG_W'(slot_q[SLOT_MEM].wsel) : '0;
    assign bus.wb_wsel  = (slot_q[SLOT_WB].valid && slot_q[SLOT_WB].regwen)
                        ? REG_W'(slot_q[SLOT_WB].wsel) : '0;

    // Control outputs are forced low while reset is held so nothing leaks out mid-reset.
    assign bus.pc_stall = nRST && pcStall;
    assign bus.bubble   = nRST && bubbleOut;
    assign bus.freeze   = nRST && freezeOut;
    assign bus.state    = state_q;

`ifdef HAZARD_STATS_EN
    sat_counter #(.W(HAZ_STAT_W)) stallCounter (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (loadUse && !bus.flush && !bus.mem_busy),
        .count_o (bus.stall_cycles)
    );

    sat_counter #(.W(HAZ_STAT_W)) freezeCounter (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (bus.mem_busy),
        .count_o (bus.freeze_cycles)
    );
`endif

endmodule
